// File: rtl/core_inst_seq.sv
// Per-core instruction sequencer: replays K load, execute, ofifo->pmem move
// and SFP normalization as a registered 19-bit core instruction stream.
module core_inst_seq #(
    parameter int COL         = 8,
    parameter int TOTAL_CYCLE = 8,
    parameter int GAP_LEN     = 10,
    parameter int SFP_LEN     = 10,
    parameter int ACC_ON      = 2,
    parameter int ACC_OFF     = 4,
    parameter int DIV_ON      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    output logic [18:0] inst,
    output logic        busy,
    output logic        done,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KLOAD  = 3'd1,
        EXEC   = 3'd2,
        MOVE   = 3'd3,
        SFP    = 3'd4,
        DONE   = 3'd5,
        GAP    = 3'd6,
        KDRAIN = 3'd7
    } state_t;

    localparam logic [7:0] COL_L   = 8'(COL);
    localparam logic [7:0] TC_L    = 8'(TOTAL_CYCLE - 1);
    localparam logic [3:0] TC_V    = 4'(TOTAL_CYCLE - 1);
    localparam logic [7:0] GAP_L   = 8'(GAP_LEN - 1);
    localparam logic [7:0] SFP_L   = 8'(SFP_LEN - 1);
    localparam logic [7:0] ACC_ONL = 8'(ACC_ON);
    localparam logic [7:0] ACC_OFL = 8'(ACC_OFF);
    localparam logic [7:0] DIV_ONL = 8'(DIV_ON);

    // load, kmem_rd, execute, qmem_rd, ofifo_rd, pmem_wr, pmem_rd
    localparam logic [18:0] STROBES = 19'h100EB;

    state_t      state, n_state;
    state_t      nphase, n_nphase;
    logic [7:0]  idx, n_idx;
    logic [3:0]  vec, n_vec;
    logic [18:0] word;
    logic        hold;

    always_comb begin
        n_state  = state;
        n_nphase = nphase;
        n_idx    = idx + 8'd1;
        n_vec    = vec;
        unique case (state)
            IDLE: begin
                n_idx = 8'd0;
                if (start) n_state = KLOAD;
            end
            KLOAD: begin
                if (idx == COL_L) begin
                    n_state = KDRAIN;
                    n_idx   = 8'd0;
                end
            end
            KDRAIN: begin
                n_state  = GAP;
                n_idx    = 8'd0;
                n_nphase = EXEC;
            end
            GAP: begin
                if (idx == GAP_L) begin
                    n_state = nphase;
                    n_idx   = 8'd0;
                end
            end
            EXEC: begin
                if (idx == TC_L) begin
                    n_state  = GAP;
                    n_idx    = 8'd0;
                    n_nphase = MOVE;
                end
            end
            MOVE: begin
                if (idx == TC_L) begin
                    n_state  = GAP;
                    n_idx    = 8'd0;
                    n_nphase = SFP;
                end
            end
            SFP: begin
                if (idx == SFP_L) begin
                    n_idx = 8'd0;
                    if (vec == TC_V) n_state = DONE;
                    else             n_vec   = vec + 4'd1;
                end
            end
            DONE: begin
                n_state = IDLE;
                n_idx   = 8'd0;
            end
            default: begin
                n_state = IDLE;
                n_idx   = 8'd0;
            end
        endcase
        if (n_state != SFP) n_vec = 4'd0;
    end

    // Word for the position about to be issued; registered below.
    always_comb begin
        word = '0;
        unique case (n_state)
            KLOAD: begin
                word[6] = 1'b1;
                word[3] = (n_idx != 8'd0);
                if (n_idx >= 8'd2) word[15:12] = n_idx[3:0] - 4'd1;
            end
            KDRAIN: word[6] = 1'b1;
            EXEC: begin
                word[7]     = 1'b1;
                word[5]     = 1'b1;
                word[15:12] = n_idx[3:0];
            end
            MOVE: begin
                word[16]   = 1'b1;
                word[0]    = 1'b1;
                word[11:8] = n_idx[3:0];
            end
            SFP: begin
                word[1]    = 1'b1;
                word[11:8] = n_vec;
                word[17]   = (n_idx >= ACC_ONL) && (n_idx < ACC_OFL);
                word[18]   = (n_idx >= DIV_ONL);
            end
            default: word = '0;
        endcase
    end

    assign hold  = stall && (state != IDLE) && (state != DONE);
    assign phase = state;

    // A stalled position is not consumed: it is re-issued in full on resume.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            nphase <= EXEC;
            idx    <= 8'd0;
            vec    <= 4'd0;
            inst   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (hold) begin
            inst <= word & ~STROBES;
            done <= 1'b0;
        end else begin
            state  <= n_state;
            nphase <= n_nphase;
            idx    <= n_idx;
            vec    <= n_vec;
            inst   <= word;
            busy   <= (n_state != IDLE);
            done   <= (n_state == DONE);
        end
    end

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: reset, golden default trace,
// stall replay and mid-run reset.
module tb_core_inst_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic [18:0] inst;
    logic        busy;
    logic        done;
    logic [2:0]  phase;

    int errors = 0;
    int checks = 0;

    localparam logic [18:0] STROBES = 19'h100EB;

    core_inst_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stall (stall),
        .inst  (inst),
        .busy  (busy),
        .done  (done),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int n,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, n, obs, expv);
        end
    endtask

    // Golden word for cycle n after the start edge, default parameters.
    function automatic logic [18:0] exp_word(input int n);
        logic [18:0] w;
        int k;
        w = '0;
        if (n >= 1 && n <= 9) begin
            k = n - 1;
            w[6] = 1'b1;
            w[3] = (k >= 1);
            if (k >= 2) w[15:12] = 4'(k - 1);
        end else if (n == 10) begin
            w[6] = 1'b1;
        end else if (n >= 21 && n <= 28) begin
            w[7] = 1'b1;
            w[5] = 1'b1;
            w[15:12] = 4'(n - 21);
        end else if (n >= 39 && n <= 46) begin
            w[16] = 1'b1;
            w[0] = 1'b1;
            w[11:8] = 4'(n - 39);
        end else if (n >= 57 && n <= 136) begin
            k = (n - 57) % 10;
            w[1] = 1'b1;
            w[11:8] = 4'((n - 57) / 10);
            w[17] = (k >= 2 && k < 4);
            w[18] = (k >= 6);
        end
        return w;
    endfunction

    initial begin
        logic [18:0] e;
        reset = 1'b1;
        start = 1'b1;
        stall = 1'b0;

        // Reset held with start high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_inst", i, 32'(inst), 32'h0);
            chk("rst_busy", i, 32'(busy), 32'h0);
            chk("rst_done", i, 32'(done), 32'h0);
            chk("rst_phase", i, 32'(phase), 32'h0);
        end

        // Full default run; a stray start at cycle 50 must be ignored
        reset = 1'b0;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 138; n++) begin
            chk("run_inst", n, 32'(inst), 32'(exp_word(n)));
            chk("run_busy", n, 32'(busy), 32'(n <= 137));
            chk("run_done", n, 32'(done), 32'(n == 137));
            if (n == 1)   chk("run_ph_kload", n, 32'(phase), 32'd1);
            if (n == 3)   chk("kload_add1", n, 32'(inst), 32'h01048);
            if (n == 10)  chk("kdrain", n, 32'(inst), 32'h00040);
            if (n == 89)  chk("sfp_v3_acc", n, 32'(inst), 32'h20302);
            if (n == 93)  chk("sfp_v3_div", n, 32'(inst), 32'h40302);
            if (n == 137) chk("run_ph_done", n, 32'(phase), 32'd5);
            if (n == 138) chk("run_ph_idle", n, 32'(phase), 32'd0);
            start = (n == 50);
            tick();
        end
        start = 1'b0;

        // Stall for 3 cycles while EXEC idx=4 is pending
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 141; n++) begin
            if (n <= 24)      e = exp_word(n);
            else if (n <= 27) e = exp_word(25) & ~STROBES;
            else              e = exp_word(n - 3);
            chk("stl_inst", n, 32'(inst), 32'(e));
            chk("stl_busy", n, 32'(busy), 32'(n <= 140));
            chk("stl_done", n, 32'(done), 32'(n == 140));
            if (n == 26) chk("stl_held", n, 32'(inst), 32'h04000);
            if (n == 28) chk("stl_replay", n, 32'(inst), 32'h040A0);
            stall = (n >= 24 && n <= 26);
            tick();
        end
        stall = 1'b0;

        // Reset during MOVE idx=5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 44; n++) begin
            chk("rmv_inst", n, 32'(inst), 32'(exp_word(n)));
            if (n == 44) begin
                chk("rmv_move5", n, 32'(inst), 32'h10501);
                reset = 1'b1;
            end
            tick();
        end
        chk("rmv_inst0", 45, 32'(inst), 32'h0);
        chk("rmv_busy0", 45, 32'(busy), 32'h0);
        chk("rmv_done0", 45, 32'(done), 32'h0);
        chk("rmv_phase0", 45, 32'(phase), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_busy", i, 32'(busy), 32'h0);
            chk("idle_inst", i, 32'(inst), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
